// File: rtl/testa_pkg.sv
// Shared types and constants for the testa serial frame generator.
// PRBS helpers are only referenced when TESTA_PRBS_EN is defined.
package testa_pkg;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    PAY = 2'd1,
    PAR = 2'd2,
    GAP = 2'd3
  } state_t;

  localparam int          HDR_W     = 8;
  localparam int          PAY_W     = 8;
  localparam logic [6:0]  PRBS_SEED = 7'h7F;
  localparam logic [2:0]  IDX_TOP   = 3'(HDR_W - 1);

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  // The next PAY_W generator output bits, MSB first, without disturbing the state.
  function automatic logic [7:0] prbs7_byte(input logic [6:0] seed);
    logic [6:0] s;
    logic [7:0] r;
    s = seed;
    r = '0;
    for (int i = PAY_W - 1; i >= 0; i--) begin
      r[i] = s[6] ^ s[5];
      s    = prbs7_step(s);
    end
    return r;
  endfunction

endpackage

// File: rtl/testa_if.sv
// Debug/observation bundle for testa: FSM state, bit index, latched payload and frame counter.
interface testa_if;
  import testa_pkg::*;

  state_t     state;
  logic [2:0] bit_idx;
  logic [7:0] payload;
  logic [7:0] frame_cnt;

  modport master (output state, bit_idx, payload, frame_cnt);
  modport slave  (input  state, bit_idx, payload, frame_cnt);
endinterface

// File: rtl/testa_prbs7.sv
// PRBS7 payload source: steps once per payload bit, frozen otherwise,
// and presents the byte it will produce over the next 8 steps.
module testa_prbs7
  import testa_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [7:0] next_byte
);

  logic [6:0] s_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q <= PRBS_SEED;
    end else if (adv) begin
      s_q <= prbs7_step(s_q);
    end
  end

  assign next_byte = prbs7_byte(s_q);

endmodule

// File: rtl/testa.sv
// Serial frame generator: SYNC_WORD header, payload byte, even parity, GAP_CYCLES idle bits.
// Define TESTA_PRBS_EN to source the payload from a PRBS7 generator instead of a frame counter.
module testa
  import testa_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD  = 8'hA5,
  parameter int         GAP_CYCLES = 3
) (
  input  logic        sclk,
  input  logic        rst,
  output logic        odata,
  testa_if.master     dbg
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] frame_cnt_q;
  logic [7:0] pay_q;
  logic [7:0] src_byte;
  logic       out_d;
  logic       leave_par;
  logic       load_pay;

`ifdef TESTA_PRBS_EN
  localparam logic [7:0] FIRST_PAY = prbs7_byte(PRBS_SEED);
  logic [7:0] prbs_byte;

  testa_prbs7 u_prbs (
    .clk       (sclk),
    .rst       (rst),
    .adv       (state_q == PAY),
    .next_byte (prbs_byte)
  );

  assign src_byte = prbs_byte;
`else
  localparam logic [7:0] FIRST_PAY = 8'h00;

  // On a PAR->HDR hop the counter increments in the same edge, so look ahead.
  assign src_byte = leave_par ? frame_cnt_q + 8'd1 : frame_cnt_q;
`endif

  // The state registers name the bit to be driven at the next edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    out_d     = 1'b0;
    leave_par = 1'b0;
    load_pay  = 1'b0;
    case (state_q)
      HDR: begin
        out_d = SYNC_WORD[idx_q];
        if (idx_q == 3'd0) begin
          state_d = PAY;
          idx_d   = IDX_TOP;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      PAY: begin
        out_d = pay_q[idx_q];
        if (idx_q == 3'd0) begin
          state_d = PAR;
          idx_d   = IDX_TOP;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      PAR: begin
        out_d     = ^pay_q;
        leave_par = 1'b1;
        if (GAP_CYCLES == 0) begin
          state_d  = HDR;
          idx_d    = IDX_TOP;
          load_pay = 1'b1;
        end else begin
          state_d = GAP;
          gap_d   = GAP_LAST;
        end
      end
      GAP: begin
        out_d = 1'b0;
        if (gap_q == 4'd0) begin
          state_d  = HDR;
          idx_d    = IDX_TOP;
          load_pay = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = HDR;
        idx_d   = IDX_TOP;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rst) begin
      state_q     <= HDR;
      idx_q       <= IDX_TOP;
      gap_q       <= 4'd0;
      frame_cnt_q <= 8'h00;
      pay_q       <= FIRST_PAY;
      odata       <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      odata   <= out_d;
      if (leave_par) frame_cnt_q <= frame_cnt_q + 8'd1;
      if (load_pay)  pay_q       <= src_byte;
    end
  end

  assign dbg.state     = state_q;
  assign dbg.bit_idx   = idx_q;
  assign dbg.payload   = pay_q;
  assign dbg.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_testa.sv
// Scoreboard bench for testa: a frame-level reference model fills expected-bit queues,
// a negedge monitor pops and compares; a second instance runs with GAP_CYCLES=0.
module tb_testa;
  import testa_pkg::*;

  localparam logic [7:0] SYNC_A = 8'hA5;
  localparam int         GAP_A  = 3;
  localparam logic [7:0] SYNC_B = 8'h3C;
  localparam int         GAP_B  = 0;

  logic sclk;
  logic rst;
  logic odata_a;
  logic odata_b;

  testa_if dbg_a ();
  testa_if dbg_b ();

  testa #(.SYNC_WORD(SYNC_A), .GAP_CYCLES(GAP_A)) u_dut (
    .sclk  (sclk),
    .rst   (rst),
    .odata (odata_a),
    .dbg   (dbg_a.master)
  );

  testa #(.SYNC_WORD(SYNC_B), .GAP_CYCLES(GAP_B)) u_dut0 (
    .sclk  (sclk),
    .rst   (rst),
    .odata (odata_b),
    .dbg   (dbg_b.master)
  );

  // clock / reset
  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  int total = 0;
  int bad   = 0;

  logic [0:0] exp_q[$];
  logic [0:0] exp0_q[$];

  // reference model state: frames generated since reset, PRBS shift state
  int         m_frames[2];
  logic [6:0] m_prbs[2];

`ifdef TESTA_PRBS_EN
  localparam logic [7:0] RESET_PAY = 8'h02;
`else
  localparam logic [7:0] RESET_PAY = 8'h00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_payload(input int which);
    logic [7:0] p;
`ifdef TESTA_PRBS_EN
    for (int i = 7; i >= 0; i--) begin
      p[i] = m_prbs[which][6] ^ m_prbs[which][5];
      m_prbs[which] = {m_prbs[which][5:0], p[i]};
    end
`else
    p = 8'(m_frames[which] % 256);
`endif
    m_frames[which]++;
    return p;
  endfunction

  task automatic push_bit(input int which, input logic b);
    if (which == 0) exp_q.push_back(b);
    else            exp0_q.push_back(b);
  endtask

  task automatic push_frame(input int which);
    logic [7:0] sync;
    logic [7:0] pay;
    int         ones;
    int         gap;
    sync = (which == 0) ? SYNC_A : SYNC_B;
    gap  = (which == 0) ? GAP_A : GAP_B;
    pay  = model_payload(which);
    ones = 0;
    for (int i = 7; i >= 0; i--) push_bit(which, sync[i]);
    for (int i = 7; i >= 0; i--) begin
      push_bit(which, pay[i]);
      ones += int'(pay[i]);
    end
    push_bit(which, (ones % 2) == 1);
    for (int i = 0; i < gap; i++) push_bit(which, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp0_q.delete();
    for (int w = 0; w < 2; w++) begin
      m_frames[w] = 0;
      m_prbs[w]   = 7'h7F;
    end
  endtask

  task automatic top_up();
    while (exp_q.size()  < 40) push_frame(0);
    while (exp0_q.size() < 40) push_frame(1);
  endtask

  // driver tasks: inputs change 1 time unit after a negedge
  task automatic do_reset(input int n);
    @(negedge sclk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (n) @(negedge sclk);
    #1;
    rst = 1'b1;
    top_up();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge sclk);
      #1;
      top_up();
    end
  endtask

  // monitor / scoreboard: rst here equals the value the DUT sampled at the last posedge
  logic [0:0] e;
  always @(negedge sclk) begin
    if (!rst) begin
      check("reset_odata_a", 32'(odata_a), 32'd0);
      check("reset_odata_b", 32'(odata_b), 32'd0);
      check("reset_state",   32'(dbg_a.state), 32'(HDR));
      check("reset_bit_idx", 32'(dbg_a.bit_idx), 32'd7);
      check("reset_frame_cnt", 32'(dbg_a.frame_cnt), 32'd0);
      check("reset_payload", 32'(dbg_b.payload), 32'(RESET_PAY));
    end else begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL underflow_a: got empty queue expected a bit at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("stream_gap3", 32'(odata_a), 32'(e));
      end
      if (exp0_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL underflow_b: got empty queue expected a bit at %0t", $time);
      end else begin
        e = exp0_q.pop_front();
        check("stream_gap0", 32'(odata_b), 32'(e));
      end
    end
  end

  initial begin
    rst = 1'b0;
    model_reset();

    // reset held, then a long run past the payload wrap (257 frames + margin)
    do_reset(2);
    run_cycles(257 * 20 + 25);

    // abort during payload bit 4 of frame 3 (bit 51 of the stream), then restart
    do_reset(2);
    run_cycles(51);
    do_reset(1);
    run_cycles(60);

    // random reset pulses at random stream positions
    for (int k = 0; k < 6; k++) begin
      run_cycles($urandom_range(300, 5));
      do_reset($urandom_range(3, 1));
    end
    run_cycles(100);

    @(negedge sclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/testa.md
TESTA -- requirements
Module: testa

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset; no other clocks or asynchronous resets exist.
REQ-002 Port sclk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  synchronous active-low reset; sampled low at a rising sclk edge = reset.
REQ-004 Port odata  output  1  registered serial frame stream, MSB-first.
REQ-005 Parameter SYNC_WORD, default 8'hA5, frame header byte.
REQ-006 Parameter GAP_CYCLES, default 3, idle cycles after each frame; legal range 0..15; 0 means back-to-back frames.

Function
REQ-007 Frame SHALL be: 8 header bits (SYNC_WORD), 8 payload bits, 1 parity bit, then GAP_CYCLES idle bits; default frame length 20 cycles.
REQ-008 FSM states HDR, PAY, PAR, GAP; transitions HDR->PAY after 8 bits, PAY->PAR after 8 bits, PAR->GAP, GAP->HDR after GAP_CYCLES bits; when GAP_CYCLES=0, PAR->HDR directly.
REQ-009 A 3-bit bit index SHALL count 7 down to 0 in HDR and PAY, reloading to 7 on each state entry.
REQ-010 odata SHALL be a flop: header/payload bit [index] in HDR/PAY, parity bit in PAR, 0 in GAP.
REQ-011 Parity SHALL be even over the 8 payload bits: parity bit = XOR of payload bits, so the 9 bits together hold an even count of ones.
REQ-012 Default payload SHALL be an 8-bit frame counter: 0x00 in the first frame after reset, +1 per frame, incremented on leaving PAR, wrapping 0xFF->0x00.
REQ-013 The payload byte SHALL be latched at HDR entry and held stable for the whole frame.
REQ-014 Latency: at the first rising edge that samples rst=1, odata SHALL become SYNC_WORD[7].

Reset
REQ-015 While rst is sampled low, odata SHALL be 0, FSM=HDR, bit index=7, frame counter=0x00 and PRBS state=7'h7F.
REQ-016 Reset asserted mid-frame SHALL abort the frame within one edge; after release the stream SHALL restart with the header and payload 0x00 (or the first PRBS byte).

Configuration
REQ-017 Macro TESTA_PRBS_EN: when defined, payload SHALL be the next 8 bits of a PRBS7 generator instead of the counter.
REQ-018 PRBS7 behaviour: seed 7'h7F; output bit b = s[6]^s[5]; update s <= {s[5:0],b}; advances 8 steps per frame, one per payload bit; first byte after reset = 0x02.
REQ-019 PRBS7 timing: it SHALL advance only during PAY and be frozen in all other states.
REQ-020 When TESTA_PRBS_EN is undefined, no PRBS logic SHALL be synthesized.
REQ-021 Header, parity, gap and reset behaviour SHALL be identical with or without TESTA_PRBS_EN.

Structure
REQ-022 Package testa_pkg SHALL hold the FSM state enum typedef, the PRBS7 seed constant (7'h7F), and the header/payload bit-width constants (8).
REQ-023 Sub-module testa_prbs7 SHALL hold the PRBS7 generator, instantiated only under TESTA_PRBS_EN.

Verification
REQ-024 Hold rst=0 for 2 cycles -> odata=0 every cycle.
REQ-025 Release reset, default config -> first 20 bits 10100101 00000000 0 000.
REQ-026 Second frame -> 10100101 00000001 1 000.
REQ-027 Run 257 frames -> frame 256 payload 0xFF, parity 0; frame 257 payload 0x00.
REQ-028 Assert rst during payload bit 4 of frame 3 -> odata=0 next edge; after release, header then payload 0x00.
REQ-029 Build with TESTA_PRBS_EN -> first frame 10100101 00000010 1 000; GAP_CYCLES=0 build -> next header starts the cycle after parity.
